// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART baud/oversample tick generator.
// baud_div() yields the rounded fixed-point oversample period in clk cycles.
package uart_pkg;

  localparam int FRAC_W_DEF = 4;

  typedef struct packed {
    logic [15:0]           div_int;
    logic [FRAC_W_DEF-1:0] div_frac;
  } baud_div_t;

  // Rounded clk_freq * 2^frac_w / (baud * os).
  function automatic longint unsigned baud_div(
    input longint unsigned clk_freq,
    input longint unsigned baud,
    input longint unsigned os,
    input int unsigned     frac_w = FRAC_W_DEF
  );
    longint unsigned num;
    longint unsigned den;
    num = clk_freq << frac_w;
    den = baud * os;
    return (num + (den / 64'd2)) / den;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Fractional-divisor oversample/baud tick generator for a UART TX/RX pair.
// Produces registered os_tick, baud_tick and mid_tick pulses plus the oversample index.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = FRAC_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          load,
  input  logic [DIV_W-1:0]              div_int,
  input  logic [FRAC_W-1:0]             div_frac,
  input  logic                          resync,
  output logic                          os_tick,
  output logic                          baud_tick,
  output logic                          mid_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_idx
);

  localparam int IDX_W = $clog2(OVERSAMPLE);
  localparam int CNT_W = DIV_W + 1;

  localparam longint unsigned DEF_DIV =
    baud_div(64'(CLK_FREQ), 64'(BAUD_RATE), 64'(OVERSAMPLE), FRAC_W);
  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEF_DIV >> FRAC_W);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_DIV);
  localparam logic [DIV_W-1:0]  MIN_DIV  = DIV_W'(2);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]  IDX_MID  = IDX_W'(OVERSAMPLE / 2 - 1);

  logic [DIV_W-1:0]  act_int_q, act_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              os_q, os_d;
  logic              baud_q, baud_d;
  logic              mid_q, mid_d;

  logic [DIV_W-1:0]  int_eff_s;
  logic [FRAC_W:0]   acc_sum_s;
  logic              carry_s;
  logic [CNT_W-1:0]  period_m1_s;
  logic              terminal_s;

  // Period length of the current oversample period (integer part plus accumulator carry).
  always_comb begin
    int_eff_s   = (act_int_q < MIN_DIV) ? MIN_DIV : act_int_q;
    acc_sum_s   = {1'b0, acc_q} + {1'b0, act_frac_q};
    carry_s     = acc_sum_s[FRAC_W];
    period_m1_s = {1'b0, int_eff_s} + CNT_W'(carry_s) - CNT_W'(1);
    terminal_s  = (cnt_q == period_m1_s);
  end

  // Next-state: load beats resync beats counting; a clear always suppresses the ticks.
  always_comb begin
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    os_d       = 1'b0;
    baud_d     = 1'b0;
    mid_d      = 1'b0;
    if (load) begin
      act_int_d  = div_int;
      act_frac_d = div_frac;
      cnt_d      = '0;
      acc_d      = '0;
      idx_d      = '0;
    end else if (resync) begin
      cnt_d = '0;
      acc_d = '0;
      idx_d = '0;
    end else if (en) begin
      if (terminal_s) begin
        cnt_d  = '0;
        acc_d  = acc_sum_s[FRAC_W-1:0];
        idx_d  = idx_q + IDX_W'(1);
        os_d   = 1'b1;
        baud_d = (idx_q == IDX_LAST);
        mid_d  = (idx_q == IDX_MID);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and registered tick outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_int_q  <= DEF_INT;
      act_frac_q <= DEF_FRAC;
      cnt_q      <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      os_q       <= 1'b0;
      baud_q     <= 1'b0;
      mid_q      <= 1'b0;
    end else begin
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      os_q       <= os_d;
      baud_q     <= baud_d;
      mid_q      <= mid_d;
    end
  end

  assign os_tick   = os_q;
  assign baud_tick = baud_q;
  assign mid_tick  = mid_q;
  assign os_idx    = idx_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: directed scenarios plus randomized traffic,
// compared each cycle against a period-arithmetic reference model.
module tb_uart_baud_gen;

  localparam int OS = 16;
  localparam int FR = 16;

  logic        clk = 1'b0;
  logic        rst, en, load, resync;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        os_tick, baud_tick, mid_tick;
  logic [3:0]  os_idx;

  uart_baud_gen dut (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .div_int(div_int), .div_frac(div_frac), .resync(resync),
    .os_tick(os_tick), .baud_tick(baud_tick), .mid_tick(mid_tick), .os_idx(os_idx)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int m_int, m_frac, m_k, m_el;
  int m_os, m_baud, m_mid;
  int t0, nb, nos, n55, n54, prev_b, prev_os, first_mid, first_b, found;
  int ts[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Period k after a clear lasts int_eff cycles plus one whenever floor(k*frac/2^F) steps up.
  function automatic int m_period(input int k);
    int eff;
    eff = (m_int < 2) ? 2 : m_int;
    return eff + ((k + 1) * m_frac) / FR - (k * m_frac) / FR;
  endfunction

  task automatic model_reset();
    m_int = 54; m_frac = 4; m_k = 0; m_el = 0;
    m_os = 0; m_baud = 0; m_mid = 0;
  endtask

  task automatic model_edge();
    m_os = 0; m_baud = 0; m_mid = 0;
    if (load) begin
      m_int = int'(div_int); m_frac = int'(div_frac); m_k = 0; m_el = 0;
    end else if (resync) begin
      m_k = 0; m_el = 0;
    end else if (en) begin
      m_el++;
      if (m_el == m_period(m_k)) begin
        m_os   = 1;
        m_baud = ((m_k % OS) == OS - 1) ? 1 : 0;
        m_mid  = ((m_k % OS) == OS / 2 - 1) ? 1 : 0;
        m_k++;
        m_el = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk("os_tick", int'(os_tick), m_os);
    chk("baud_tick", int'(baud_tick), m_baud);
    chk("mid_tick", int'(mid_tick), m_mid);
    chk("os_idx", int'(os_idx), m_k % OS);
  endtask

  task automatic do_load(input int di, input int df);
    load = 1'b1; div_int = 16'(di); div_frac = 4'(df);
    step();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; resync = 1'b0;
    div_int = 16'd0; div_frac = 4'd0;
    model_reset();
    #12;
    chk("rst_os_tick", int'(os_tick), 0);
    chk("rst_baud_tick", int'(baud_tick), 0);
    chk("rst_mid_tick", int'(mid_tick), 0);
    chk("rst_os_idx", int'(os_idx), 0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;

    // Default divisor: 868-cycle bits, os spacing 54/55 with four 55s per 16 periods.
    cyc = 0; nb = 0; nos = 0; n55 = 0; n54 = 0; prev_b = 0; prev_os = 0;
    for (int i = 0; i < 12000 && nb < 11; i++) begin
      step();
      if (os_tick) begin
        if (nos == 0) chk("first_os_after_reset", cyc, 54);
        else if (nos <= 16) begin
          if (cyc - prev_os == 55) n55++;
          else if (cyc - prev_os == 54) n54++;
          else chk("os_spacing_default", cyc - prev_os, 54);
        end
        nos++;
        prev_os = cyc;
      end
      if (baud_tick) begin
        chk("baud_spacing_default", cyc - prev_b, 868);
        nb++;
        prev_b = cyc;
      end
    end
    chk("baud_count_default", nb, 11);
    chk("os_55_count", n55, 4);
    chk("os_54_count", n54, 12);

    // Integer divisor 4: mid 32 and baud 64 cycles after resync, index wraps on baud.
    do_load(4, 0);
    for (int i = 0; i < 23; i++) step();
    resync = 1'b1; step(); resync = 1'b0;
    t0 = cyc; first_mid = -1; first_b = -1;
    for (int i = 0; i < 80; i++) begin
      step();
      if (mid_tick && first_mid < 0) first_mid = cyc - t0;
      if (baud_tick && first_b < 0) begin
        first_b = cyc - t0;
        chk("os_idx_wrap_on_baud", int'(os_idx), 0);
      end
    end
    chk("mid_after_resync", first_mid, 32);
    chk("baud_after_resync", first_b, 64);

    // Half-cycle fraction: periods alternate 4,5,4,5.
    do_load(4, 8);
    t0 = cyc; ts.delete();
    for (int i = 0; i < 30; i++) begin
      step();
      if (os_tick) ts.push_back(cyc - t0);
    end
    chk("frac_tick_count", (ts.size() >= 4) ? 1 : 0, 1);
    if (ts.size() >= 4) begin
      chk("frac_p0", ts[0], 4);
      chk("frac_p1", ts[1] - ts[0], 5);
      chk("frac_p2", ts[2] - ts[1], 4);
      chk("frac_p3", ts[3] - ts[2], 5);
    end

    // Enable dropped 7 cycles mid-period delays subsequent ticks by exactly 7.
    do_load(6, 0);
    t0 = cyc; ts.delete();
    for (int i = 0; i < 9; i++) begin
      step();
      if (os_tick) ts.push_back(cyc - t0);
    end
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (os_tick) ts.push_back(cyc - t0);
    end
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (os_tick) ts.push_back(cyc - t0);
    end
    chk("en_tick_count", (ts.size() >= 3) ? 1 : 0, 1);
    if (ts.size() >= 3) begin
      chk("en_t0", ts[0], 6);
      chk("en_t1", ts[1], 19);
      chk("en_t2", ts[2], 25);
    end

    // Resync on a terminal count suppresses the tick; next tick P later with index 1.
    do_load(5, 0);
    for (int i = 0; i < 7; i++) step();
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      if (m_el + 1 == m_period(m_k)) found = 1;
      else step();
    end
    chk("terminal_found", found, 1);
    resync = 1'b1; step(); resync = 1'b0;
    chk("resync_terminal_no_tick", int'(os_tick), 0);
    t0 = cyc; first_b = -1;
    for (int i = 0; i < 20 && first_b < 0; i++) begin
      step();
      if (os_tick) begin
        first_b = cyc - t0;
        chk("resync_next_idx", int'(os_idx), 1);
      end
    end
    chk("resync_next_os", first_b, 5);

    // Integer divisor 1 is clamped to a 2-cycle period.
    do_load(1, 0);
    t0 = cyc; ts.delete();
    for (int i = 0; i < 10; i++) begin
      step();
      if (os_tick) ts.push_back(cyc - t0);
    end
    chk("clamp_count", ts.size(), 5);
    if (ts.size() >= 2) begin
      chk("clamp_t0", ts[0], 2);
      chk("clamp_t1", ts[1], 4);
    end

    // Asynchronous reset mid-bit restores the default divisor.
    do_load(3, 0);
    for (int i = 0; i < 40; i++) step();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_os_tick", int'(os_tick), 0);
    chk("arst_baud_tick", int'(baud_tick), 0);
    chk("arst_mid_tick", int'(mid_tick), 0);
    chk("arst_os_idx", int'(os_idx), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    t0 = cyc; first_b = -1;
    for (int i = 0; i < 100 && first_b < 0; i++) begin
      step();
      if (os_tick) first_b = cyc - t0;
    end
    chk("arst_first_os", first_b, 54);

    // Randomized enable/resync/load traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      resync   = ($urandom_range(0, 99) == 0);
      load     = ($urandom_range(0, 199) == 0);
      div_int  = 16'($urandom_range(0, 7));
      div_frac = 4'($urandom);
      step();
    end
    en = 1'b0; resync = 1'b0; load = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_baud_gen.md
# uart_baud_gen

Parametrised UART baud/oversample tick generator with fractional divisor, runtime reprogramming, enable and phase resync. It drives the UART transmitter (`baud_tick`) and receiver (`os_tick`, `mid_tick`, `os_idx`). It generalises the fixed-rate divider with these additions:
- fractional rate accuracy;
- N-times oversampling;
- start-bit phase alignment.

## Interface
- `CLK_FREQ`, 100000000: system clock in Hz.
- `BAUD_RATE`, 115200: reset-time baud rate.
- `OVERSAMPLE`, 16: oversample ticks per bit; power of two, ≥4.
- `DIV_W`, 16: integer divisor width.
- `FRAC_W`, 4: fractional divisor width.
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  count enable.
- `load`  in  1  one-cycle pulse; latches `div_int`/`div_frac` as the active divisor.
- `div_int`  in  DIV_W  integer part of the oversample period, in clk cycles.
- `div_frac`  in  FRAC_W  fractional part, in units of 1/2^FRAC_W cycle.
- `resync`  in  1  one-cycle pulse; restarts the bit phase (RX start-bit edge).
- `os_tick`  out  1  one-cycle pulse per oversample period.
- `baud_tick`  out  1  one-cycle pulse per bit period.
- `mid_tick`  out  1  one-cycle pulse at mid-bit.
- `os_idx`  out  $clog2(OVERSAMPLE)  oversample index within the current bit.

## Operation
- Active divisor registers `act_int`/`act_frac` reset to `DEF_DIV` = round(CLK_FREQ·2^FRAC_W / (BAUD_RATE·OVERSAMPLE)), split into integer and fractional parts. Defaults give 868 → int 54, frac 4.
- Effective integer divisor is max(`act_int`, 2). Values 0 and 1 are clamped to 2.
- Fractional accumulator `acc` is FRAC_W bits. Carry of the current period: `c` = carry-out of `acc + act_frac`. Period length = `act_int_eff + c` cycles.
- Counter `cnt` increments on every cycle with `en`=1.
- When `cnt` = period−1 on an enabled edge:
  - `cnt` ← 0;
  - `acc` ← low FRAC_W bits of (`acc + act_frac`);
  - `os_idx` ← `os_idx`+1, wrapping from OVERSAMPLE−1 to 0;
  - `os_tick` ← 1.
- `baud_tick` ← 1 together with `os_tick` when the pre-increment `os_idx` = OVERSAMPLE−1.
- `mid_tick` ← 1 together with `os_tick` when the pre-increment `os_idx` = OVERSAMPLE/2−1.
- All tick outputs are registered and high for exactly one cycle. Otherwise 0.
- `en`=0: `cnt`, `acc` and `os_idx` hold; all ticks are 0 in the following cycle.
- `resync`: `cnt`, `acc` and `os_idx` ← 0; ticks are suppressed in that edge's update. Takes effect regardless of `en`.
- `load`: latches the divisor and performs the same clear as `resync`. With `load` and `resync` together, the result equals `load` alone.
- A resync or load coincident with a terminal count wins: no tick is emitted.

## Timing
- Reset (async assert): `os_tick`=`baud_tick`=`mid_tick`=0, `os_idx`=0, `cnt`=0, `acc`=0, active divisor = `DEF_DIV`.
- Reset asserted mid-period aborts immediately. Counting restarts from 0 on the first enabled edge after deassertion.
- With `en` high and integer period P, `os_tick` is first high P cycles after the first enabled edge, then every P cycles.
- `baud_tick` occurs every OVERSAMPLE `os_tick`s; its first occurrence is OVERSAMPLE·P cycles after the clear.
- `mid_tick` is first high (OVERSAMPLE/2)·P cycles after `resync`.
- A new divisor applies to the very next period after `load`; there is no partially-old period.
- Over 2^FRAC_W consecutive periods, the total cycle count is exactly 2^FRAC_W·`act_int_eff` + `act_frac`.

## Structure
- `uart_pkg`:
  - `FRAC_W` default;
  - function `baud_div(clk_freq, baud, os)`, which returns the rounded fixed-point divisor;
  - typedef `baud_div_t` (struct of int/frac).
- Single module is sufficient. Optional sub-module `frac_accum` holds `acc` and the carry logic, in/out = `act_frac`, step, carry.
- `cnt` is DIV_W+1 bits wide so that period `act_int`+1 never overflows.

## Test plan
- Defaults (54 + 4/16, OS=16), `en`=1 → `baud_tick` spacing exactly 868 cycles across 10 bits; `os_tick` spacings are 54 or 55, with four 55s per 16 periods.
- `load` `div_int`=4, `div_frac`=0 → `os_tick` every 4 cycles, `baud_tick` every 64, `mid_tick` 32 cycles after `resync`, `os_idx` wraps 15 → 0 on `baud_tick`.
- `load` `div_int`=4, `div_frac`=8 → `os_tick` periods alternate 4, 5, 4, 5, …
- `en` dropped for 7 cycles mid-period → all ticks delayed by exactly 7 cycles; none lost or duplicated.
- `resync` coincident with a terminal count → no tick that cycle; next `os_tick` P cycles later with `os_idx`=1. `load` `div_int`=1 → period clamped to 2.
- `rst` pulsed asynchronously mid-bit → outputs 0 immediately; active divisor back to 54/4; first `os_tick` 54 cycles after restart.
